// File: rtl/mem_bus_arbiter.sv
// Purpose : two-master round-robin arbiter in front of a single memory/peripheral bus.
// Latency : req in IDLE -> mem_req next cycle; done one cycle after mem_ack (min 4 cycles/txn).
// Backpr. : one command in flight; requesters hold req until done, the loser waits for IDLE.
//
// Ports:
//   clk50M, rst                 - clock, asynchronous active-high reset
//   m{0,1}_req/is_write/addr/wdata - master commands, held stable while req is high
//   m{0,1}_rdata/done/err       - per-master completion (rdata held until that port's next done)
//   mem_req/is_write/addr/wdata - one-cycle issue strobe plus latched command
//   mem_rdata/mem_ack           - controller read data and completion pulse
//   grant, busy                 - owner of current/last transaction, non-IDLE indicator
// Optional: define MEM_ARB_TIMEOUT_EN to bound the WAIT state to TIMEOUT_CYCLES cycles.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk50M,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_is_write,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_done,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_is_write,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_done,
  output logic                  m1_err,
  output logic                  mem_req,
  output logic                  mem_is_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  grant,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    last_grant_q, last_grant_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_is_write_q, mem_is_write_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0]   m1_rdata_q, m1_rdata_d;
  logic                    m0_done_q, m0_done_d;
  logic                    m1_done_q, m1_done_d;
  logic                    m0_err_q, m0_err_d;
  logic                    m1_err_q, m1_err_d;
  logic                    busy_q, busy_d;

  logic                    any_req;
  logic                    pick;
  logic                    tmo;   // WAIT gives up this cycle (never when mem_ack is present)
  logic [DATA_WIDTH-1:0]   rd_val;

  assign any_req = m0_req | m1_req;
  // On a tie the port that did not own the last transaction wins.
  assign pick    = (m0_req && m1_req) ? ~last_grant_q : m1_req;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts completed ack-less WAIT cycles; the limit is hit when this
  // cycle would make it TIMEOUT_CYCLES, so mem_ack in that cycle still wins.
  assign tmo = (state_q == S_WAIT) && !mem_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_ISSUE) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT && !mem_ack) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Without the timeout WAIT is unbounded; the limit parameter has no effect.
  assign tmo = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // State register (all flops).
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      grant_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      mem_req_q      <= 1'b0;
      mem_is_write_q <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      m0_rdata_q     <= '0;
      m1_rdata_q     <= '0;
      m0_done_q      <= 1'b0;
      m1_done_q      <= 1'b0;
      m0_err_q       <= 1'b0;
      m1_err_q       <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      mem_req_q      <= mem_req_d;
      mem_is_write_q <= mem_is_write_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      m0_rdata_q     <= m0_rdata_d;
      m1_rdata_q     <= m1_rdata_d;
      m0_done_q      <= m0_done_d;
      m1_done_q      <= m1_done_d;
      m0_err_q       <= m0_err_d;
      m1_err_q       <= m1_err_d;
      busy_q         <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;   // mem_ack deliberately ignored here
      S_WAIT:  if (mem_ack || tmo) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic. Every output is the registered image of a
  // value computed from the next state, so nothing reaches a port combinationally.
  always_comb begin
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    mem_is_write_d = mem_is_write_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    m0_rdata_d     = m0_rdata_q;
    m1_rdata_d     = m1_rdata_q;
    rd_val         = mem_ack ? mem_rdata : '1;

    if (state_q == S_IDLE && any_req) begin
      grant_d        = pick;
      mem_is_write_d = pick ? m1_is_write : m0_is_write;
      mem_addr_d     = pick ? m1_addr     : m0_addr;
      mem_wdata_d    = pick ? m1_wdata    : m0_wdata;
    end

    if (state_q == S_DONE) begin
      last_grant_d = grant_q;
    end

    // Reads capture controller data on ack, or all ones on timeout; writes keep rdata.
    if (state_q == S_WAIT && !mem_is_write_q && (mem_ack || tmo)) begin
      if (grant_q) begin
        m1_rdata_d = rd_val;
      end else begin
        m0_rdata_d = rd_val;
      end
    end

    mem_req_d = (state_d == S_ISSUE);
    busy_d    = (state_d != S_IDLE);
    m0_done_d = (state_d == S_DONE) && !grant_q;
    m1_done_d = (state_d == S_DONE) &&  grant_q;
    m0_err_d  = tmo && !grant_q;
    m1_err_d  = tmo &&  grant_q;
  end

  assign grant        = grant_q;
  assign busy         = busy_q;
  assign mem_req      = mem_req_q;
  assign mem_is_write = mem_is_write_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign m0_rdata     = m0_rdata_q;
  assign m1_rdata     = m1_rdata_q;
  assign m0_done      = m0_done_q;
  assign m1_done      = m1_done_q;
  assign m0_err       = m0_err_q;
  assign m1_err       = m1_err_q;

endmodule
